// File: rtl/stopwatch_display_if.sv
// Stopwatch display bus: BCD digits from the counter, scanned segment/anode lines to the board.
// Latency: none (bundle of wires only).
// Backpressure: none; digits are sampled once per frame, outputs are free-running.
// Ports: d0..d3 BCD digits (d0 rightmost), an active-low anodes,
//        seg active-low {g,f,e,d,c,b,a}, dp active-low decimal point.
interface stopwatch_display_if;
  logic [3:0] d0;
  logic [3:0] d1;
  logic [3:0] d2;
  logic [3:0] d3;
  logic [3:0] an;
  logic [6:0] seg;
  logic       dp;

  // master: the stopwatch counter side, supplies digits and sees the display lines
  modport master (output d0, d1, d2, d3, input an, seg, dp);
  // slave: the display driver
  modport slave  (input d0, d1, d2, d3, output an, seg, dp);
endinterface

// File: rtl/stopwatch_display.sv
// Four-digit multiplexed common-anode seven-segment driver with per-frame digit snapshot,
// leading-zero blanking, fixed decimal point and an all-off guard time at each slot start.
// Latency: outputs registered, one cycle behind prescaler/select/shadow state; no backpressure.
// Ports: clk (system clock), reset (async active-high), sw (slave modport: d0..d3 in, an/seg/dp out).
module stopwatch_display #(
  parameter int REFRESH_DIV = 100000,  // cycles per digit slot, >= 4
  parameter int GUARD       = 16,      // all-anodes-off cycles at slot start, < REFRESH_DIV
  parameter int DP_POS      = 2,       // digit index whose decimal point is lit
  parameter int BLANK_LZ    = 1        // 1 enables leading-zero blanking
) (
  input  logic                clk,
  input  logic                reset,
  stopwatch_display_if.slave  sw
);

  localparam int              PW        = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam logic [PW-1:0]   PRESC_MAX = PW'(REFRESH_DIV - 1);

  logic [PW-1:0]     presc_q, presc_d;
  logic [1:0]        sel_q, sel_d;
  logic [3:0][3:0]   shadow_q, shadow_d;
  logic [3:0]        an_q, an_d;
  logic [6:0]        seg_q, seg_d;
  logic              dp_q, dp_d;

  logic              tick;
  logic [3:0]        digit;
  logic [3:0]        zero_up;   // zero_up[k]: digits k..3 of the shadow are all zero
  logic              blank;
  logic              in_guard;

  function automatic logic [6:0] decode7(input logic [3:0] v);
    logic [6:0] s;
    case (v)
      4'd0:    s = 7'b1000000;
      4'd1:    s = 7'b1111001;
      4'd2:    s = 7'b0100100;
      4'd3:    s = 7'b0110000;
      4'd4:    s = 7'b0011001;
      4'd5:    s = 7'b0010010;
      4'd6:    s = 7'b0000010;
      4'd7:    s = 7'b1111000;
      4'd8:    s = 7'b0000000;
      4'd9:    s = 7'b0010000;
      default: s = 7'b0111111;  // invalid BCD shows a dash
    endcase
    return s;
  endfunction

  always_comb begin
    tick    = (presc_q == PRESC_MAX);
    presc_d = tick ? '0 : presc_q + PW'(1);
    sel_d   = tick ? sel_q + 2'd1 : sel_q;

    // Snapshot only on the edge that closes slot 3, so a frame never mixes old and new digits.
    shadow_d = shadow_q;
    if (tick && (sel_q == 2'd3)) begin
      shadow_d = {sw.d3, sw.d2, sw.d1, sw.d0};
    end

    digit = shadow_q[sel_q];

    zero_up[3] = (shadow_q[3] == 4'd0);
    for (int k = 2; k >= 0; k--) begin
      zero_up[k] = zero_up[k+1] && (shadow_q[k] == 4'd0);
    end

    // Digits left of the decimal point blank while they and everything above them are zero;
    // digit 0 always shows.
    blank = (BLANK_LZ != 0) && (sel_q != 2'd0) && (int'(sel_q) > DP_POS) && zero_up[sel_q];

    in_guard = (int'(presc_q) < GUARD);

    an_d  = 4'b1111;
    seg_d = 7'b1111111;
    dp_d  = 1'b1;
    if (!in_guard) begin
      an_d  = ~(4'b0001 << sel_q);
      seg_d = blank ? 7'b1111111 : decode7(digit);
      dp_d  = !((int'(sel_q) == DP_POS) && !blank);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      presc_q  <= '0;
      sel_q    <= 2'd0;
      shadow_q <= '0;
      an_q     <= 4'b1111;
      seg_q    <= 7'b1111111;
      dp_q     <= 1'b1;
    end else begin
      presc_q  <= presc_d;
      sel_q    <= sel_d;
      shadow_q <= shadow_d;
      an_q     <= an_d;
      seg_q    <= seg_d;
      dp_q     <= dp_d;
    end
  end

  assign sw.an  = an_q;
  assign sw.seg = seg_q;
  assign sw.dp  = dp_q;

endmodule
